// File: rtl/alu_pkg.sv
// Shared opcode encodings, sequencer state type and width default for the ALU sequencer slice.
package alu_pkg;

  localparam int DW_DEFAULT = 16;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_LDI  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_NAND = 4'd7;
  localparam logic [3:0] OP_NOR  = 4'd8;
  localparam logic [3:0] OP_NOT  = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Opcodes that go through the external ALU (ADD..NOT); 10-15 are illegal.
  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_NOT);
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Command, result and ALU-operand bus between the instruction source / ALU side (master)
// and the sequencer (slave).
interface alu_sequencer_if
  import alu_pkg::*;
#(
  parameter int DW  = DW_DEFAULT,
  parameter int RAW = 3
);
  logic           cmd_valid;
  logic           cmd_ready;
  logic [3:0]     cmd_op;
  logic [RAW-1:0] cmd_dst;
  logic [RAW-1:0] cmd_srca;
  logic [RAW-1:0] cmd_srcb;
  logic [DW-1:0]  cmd_imm;

  logic [DW-1:0]  alu_a;
  logic [DW-1:0]  alu_b;
  logic [3:0]     alu_opcode;
  logic [DW-1:0]  alu_result;

  logic           res_valid;
  logic           res_ready;
  logic [DW-1:0]  res_data;
  logic [RAW-1:0] res_dst;

  logic           busy;
  logic           err_illegal;

  modport master (
    output cmd_valid, cmd_op, cmd_dst, cmd_srca, cmd_srcb, cmd_imm,
    input  cmd_ready,
    input  alu_a, alu_b, alu_opcode,
    output alu_result,
    input  res_valid, res_data, res_dst,
    output res_ready,
    input  busy, err_illegal
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_dst, cmd_srca, cmd_srcb, cmd_imm,
    output cmd_ready,
    output alu_a, alu_b, alu_opcode,
    input  alu_result,
    output res_valid, res_data, res_dst,
    input  res_ready,
    output busy, err_illegal
  );

endinterface

// File: rtl/alu_regfile.sv
// NREG x DW register file: one synchronous write port, two asynchronous read ports,
// cleared to zero on reset.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int DW   = DW_DEFAULT,
  parameter int NREG = 8,
  parameter int RAW  = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           we,
  input  logic [RAW-1:0] waddr,
  input  logic [DW-1:0]  wdata,
  input  logic [RAW-1:0] raddr_a,
  input  logic [RAW-1:0] raddr_b,
  output logic [DW-1:0]  rdata_a,
  output logic [DW-1:0]  rdata_b
);

  logic [DW-1:0] mem [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/alu_sequencer.sv
// Command sequencer: accepts one command, reads operands, drives the external ALU,
// writes the result back and returns it over the result handshake.
//
//  state | meaning
//  IDLE  | ready for a command; NOP/illegal are consumed here
//  EXEC  | ALU operands registered; capture alu_result next edge
//  RESP  | result presented until res_ready
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int DW   = DW_DEFAULT,
  parameter int NREG = 8,
  parameter int RAW  = 3
) (
  input logic            clk,
  input logic            rst,
  alu_sequencer_if.slave bus
);

  state_t         state;
  logic [RAW-1:0] dst_q;
  logic [DW-1:0]  alu_a_q;
  logic [DW-1:0]  alu_b_q;
  logic [3:0]     alu_op_q;
  logic [DW-1:0]  res_data_q;
  logic [RAW-1:0] res_dst_q;
  logic           err_q;

  logic           rf_we;
  logic [RAW-1:0] rf_waddr;
  logic [DW-1:0]  rf_wdata;
  logic [DW-1:0]  rd_a;
  logic [DW-1:0]  rd_b;

  // Write port: LDI writes straight from the command, ALU ops write back during EXEC.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = dst_q;
    rf_wdata = bus.alu_result;
    if (state == EXEC) begin
      rf_we = 1'b1;
    end else if (state == IDLE && bus.cmd_valid && bus.cmd_op == OP_LDI) begin
      rf_we    = 1'b1;
      rf_waddr = bus.cmd_dst;
      rf_wdata = bus.cmd_imm;
    end
  end

  alu_regfile #(
    .DW   (DW),
    .NREG (NREG),
    .RAW  (RAW)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .raddr_a (bus.cmd_srca),
    .raddr_b (bus.cmd_srcb),
    .rdata_a (rd_a),
    .rdata_b (rd_b)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      dst_q      <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      res_data_q <= '0;
      res_dst_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            if (is_alu_op(bus.cmd_op)) begin
              alu_a_q  <= rd_a;
              alu_b_q  <= rd_b;
              alu_op_q <= bus.cmd_op;
              dst_q    <= bus.cmd_dst;
              state    <= EXEC;
            end else if (bus.cmd_op == OP_LDI) begin
              res_data_q <= bus.cmd_imm;
              res_dst_q  <= bus.cmd_dst;
              state      <= RESP;
            end else if (bus.cmd_op != OP_NOP) begin
              err_q <= 1'b1;
            end
          end
        end
        EXEC: begin
          res_data_q <= bus.alu_result;
          res_dst_q  <= dst_q;
          state      <= RESP;
        end
        RESP: begin
          if (bus.res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready   = (state == IDLE);
  assign bus.busy        = (state != IDLE);
  assign bus.res_valid   = (state == RESP);
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_opcode  = alu_op_q;
  assign bus.res_data    = res_data_q;
  assign bus.res_dst     = res_dst_q;
  assign bus.err_illegal = err_q;

endmodule
